// File: rtl/addr_rr_arbiter.sv
// rtl/addr_rr_arbiter.sv - write-address arbiter with registered output stage and grant-order FIFO
module addr_rr_arbiter #(
  parameter int NUM_S     = 3,
  parameter int ADDR_W    = 12,
  parameter int LEN_W     = 8,
  parameter int ID_W      = 6,
  parameter int ARB_MODE  = 0,
  parameter int ORD_DEPTH = 4,
  localparam int IDX_W    = (NUM_S > 1) ? $clog2(NUM_S) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_S*ADDR_W-1:0] s_awaddr,
  input  logic [NUM_S*LEN_W-1:0]  s_awlen,
  input  logic [NUM_S*3-1:0]      s_awsize,
  input  logic [NUM_S*2-1:0]      s_awburst,
  input  logic [NUM_S*ID_W-1:0]   s_awid,
  input  logic [NUM_S-1:0]        s_awvalid,
  output logic [NUM_S-1:0]        s_awready,
  output logic [ADDR_W-1:0]       m_awaddr,
  output logic [LEN_W-1:0]        m_awlen,
  output logic [2:0]              m_awsize,
  output logic [1:0]              m_awburst,
  output logic [ID_W-1:0]         m_awid,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [IDX_W-1:0]        wsel_idx,
  output logic                    wsel_valid,
  input  logic                    wsel_pop
);

  localparam int PTR_W = (ORD_DEPTH > 1) ? $clog2(ORD_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [NUM_S-1:0]   ptr_q;
  logic [NUM_S-1:0]   hi_mask;
  logic [NUM_S-1:0]   req_hi;
  logic [NUM_S-1:0]   req_pick;
  logic [NUM_S-1:0]   grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               mask_acc;
  logic               any_req;
  logic               load_en;
  logic               load;
  logic               pop_ok;
  logic               fifo_full;

  logic [ADDR_W-1:0]  sel_addr;
  logic [LEN_W-1:0]   sel_len;
  logic [2:0]         sel_size;
  logic [1:0]         sel_burst;
  logic [ID_W-1:0]    sel_id;

  logic [IDX_W-1:0]   ord_mem [ORD_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;

  // Thermometer mask of indices at or above the round-robin pointer.
  always_comb begin
    hi_mask  = '0;
    mask_acc = 1'b0;
    for (int i = 0; i < NUM_S; i++) begin
      mask_acc   = mask_acc | ptr_q[i];
      hi_mask[i] = mask_acc;
    end
  end

  // Prefer requests at/above the pointer; fall back to the wrapped-around set. Fixed mode searches from 0.
  always_comb begin
    req_hi   = (ARB_MODE != 0) ? s_awvalid : (s_awvalid & hi_mask);
    req_pick = (|req_hi) ? req_hi : s_awvalid;
    grant    = '0;
    for (int i = NUM_S - 1; i >= 0; i--) begin
      if (req_pick[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
  end

  // Binary index and payload of the granted source.
  always_comb begin
    grant_idx = '0;
    sel_addr  = '0;
    sel_len   = '0;
    sel_size  = '0;
    sel_burst = '0;
    sel_id    = '0;
    for (int i = 0; i < NUM_S; i++) begin
      if (grant[i]) begin
        grant_idx = IDX_W'(i);
        sel_addr  = s_awaddr[i*ADDR_W +: ADDR_W];
        sel_len   = s_awlen[i*LEN_W +: LEN_W];
        sel_size  = s_awsize[i*3 +: 3];
        sel_burst = s_awburst[i*2 +: 2];
        sel_id    = s_awid[i*ID_W +: ID_W];
      end
    end
  end

  // A load needs a free output slot and a free order slot; a retiring entry frees one in the same cycle.
  always_comb begin
    any_req    = |s_awvalid;
    wsel_valid = (count_q != '0);
    fifo_full  = (count_q == CNT_W'(ORD_DEPTH));
    pop_ok     = wsel_pop & wsel_valid & ~rst;
    load_en    = ~rst & ((state_q == ST_EMPTY) | m_awready) & (~fifo_full | pop_ok);
    load       = load_en & any_req;
    s_awready  = load_en ? grant : '0;
    wsel_idx   = wsel_valid ? ord_mem[rd_ptr_q] : '0;
  end

  // Output-stage state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Output-stage next state: a held beat leaves only on m_awready; a load refills it.
  always_comb begin
    state_d   = state_q;
    m_awvalid = (state_q == ST_FULL);
    case (state_q)
      ST_EMPTY: if (load) state_d = ST_FULL;
      ST_FULL:  if (m_awready && !load) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // Registered downstream payload, captured only on a load.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_awaddr  <= '0;
      m_awlen   <= '0;
      m_awsize  <= '0;
      m_awburst <= '0;
      m_awid    <= '0;
    end else if (load) begin
      m_awaddr  <= sel_addr;
      m_awlen   <= sel_len;
      m_awsize  <= sel_size;
      m_awburst <= sel_burst;
      m_awid    <= sel_id;
    end
  end

  // Round-robin pointer moves one past the source just loaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q    <= '0;
      ptr_q[0] <= 1'b1;
    end else if (load) begin
      ptr_q <= {grant[NUM_S-2:0], grant[NUM_S-1]};
    end
  end

  // Grant-order FIFO pointers and occupancy; pointers wrap naturally since depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (load)   wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({load, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Grant-order storage; stale entries are masked by wsel_valid so no reset is needed.
  always_ff @(posedge clk) begin
    if (load) ord_mem[wr_ptr_q] <= grant_idx;
  end

endmodule
